// File: rtl/i_decode_pkg.sv
// Shared constants, control-group layout and opcode decode for the ID stage.
package i_decode_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 3;
    localparam int unsigned EX_W   = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

    // wb = {RegWrite, MemtoReg}; m = {Branch, MemRead, MemWrite}; ex = {RegDst, ALUOp, ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_RTYPE = ctrl_t'({2'b10, 3'b000, 4'b1100});
    localparam ctrl_t CTRL_LW    = ctrl_t'({2'b11, 3'b010, 4'b0001});
    localparam ctrl_t CTRL_SW    = ctrl_t'({2'b00, 3'b001, 4'b0001});
    localparam ctrl_t CTRL_BEQ   = ctrl_t'({2'b00, 3'b100, 4'b0010});
    localparam ctrl_t CTRL_NOP   = ctrl_t'('0);

    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: c = CTRL_RTYPE;
            OP_LW:    c = CTRL_LW;
            OP_SW:    c = CTRL_SW;
            OP_BEQ:   c = CTRL_BEQ;
            default:  c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// 32x32 register file: one synchronous write port, two combinational read ports
// with write-through bypass, r0 hardwired to zero.
module reg_file
    import i_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1_c,
    output logic [XLEN-1:0]   rdata2_c
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass makes the value being written this cycle visible to the reader.
    always_comb begin
        rdata1_c = '0;
        rdata2_c = '0;
        if (raddr1 != '0) begin
            rdata1_c = (wr_en && (waddr == raddr1)) ? wdata : regs[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2_c = (wr_en && (waddr == raddr2)) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: register read, immediate sign-extension, control decode
// and the ID/EX pipeline register.
module i_decode
    import i_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   IF_ID_instruction,
    input  logic [XLEN-1:0]   IF_ID_npc,
    input  logic              MEM_WB_reg_write,
    input  logic [REG_AW-1:0] MEM_WB_write_reg,
    input  logic [XLEN-1:0]   MEM_WB_write_data,
    input  logic              ID_EX_flush,
    output logic [WB_W-1:0]   ID_EX_wb,
    output logic [M_W-1:0]    ID_EX_m,
    output logic [EX_W-1:0]   ID_EX_ex,
    output logic [XLEN-1:0]   ID_EX_npc,
    output logic [XLEN-1:0]   ID_EX_readdat1,
    output logic [XLEN-1:0]   ID_EX_readdat2,
    output logic [XLEN-1:0]   ID_EX_sign_ext,
    output logic [REG_AW-1:0] ID_EX_instr_2016,
    output logic [REG_AW-1:0] ID_EX_instr_1511
);

    logic [XLEN-1:0] rdata1_c;
    logic [XLEN-1:0] rdata2_c;
    logic [XLEN-1:0] sign_ext_c;
    ctrl_t           ctrl_c;

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (MEM_WB_reg_write),
        .waddr    (MEM_WB_write_reg),
        .wdata    (MEM_WB_write_data),
        .raddr1   (IF_ID_instruction[25:21]),
        .raddr2   (IF_ID_instruction[20:16]),
        .rdata1_c (rdata1_c),
        .rdata2_c (rdata2_c)
    );

    assign sign_ext_c = {{16{IF_ID_instruction[15]}}, IF_ID_instruction[15:0]};
    assign ctrl_c     = decode_ctrl(IF_ID_instruction[31:26]);

    // A flush bubbles only the control groups; data fields still advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_wb         <= '0;
            ID_EX_m          <= '0;
            ID_EX_ex         <= '0;
            ID_EX_npc        <= '0;
            ID_EX_readdat1   <= '0;
            ID_EX_readdat2   <= '0;
            ID_EX_sign_ext   <= '0;
            ID_EX_instr_2016 <= '0;
            ID_EX_instr_1511 <= '0;
        end else begin
            ID_EX_wb         <= ID_EX_flush ? WB_W'(0) : ctrl_c.wb;
            ID_EX_m          <= ID_EX_flush ? M_W'(0)  : ctrl_c.m;
            ID_EX_ex         <= ID_EX_flush ? EX_W'(0) : ctrl_c.ex;
            ID_EX_npc        <= IF_ID_npc;
            ID_EX_readdat1   <= rdata1_c;
            ID_EX_readdat2   <= rdata2_c;
            ID_EX_sign_ext   <= sign_ext_c;
            ID_EX_instr_2016 <= IF_ID_instruction[20:16];
            ID_EX_instr_1511 <= IF_ID_instruction[15:11];
        end
    end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: random and directed stimulus against a register-array model.
module tb_i_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, npc, wdata;
    logic        we, flush;
    logic [4:0]  waddr;
    logic [1:0]  o_wb;
    logic [2:0]  o_m;
    logic [3:0]  o_ex;
    logic [31:0] o_npc, o_rd1, o_rd2, o_sext;
    logic [4:0]  o_i2016, o_i1511;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sext;
        logic [4:0]  i2016, i1511;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_regs [32];

    always #5 clk = ~clk;

    i_decode dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IF_ID_instruction (instr),
        .IF_ID_npc         (npc),
        .MEM_WB_reg_write  (we),
        .MEM_WB_write_reg  (waddr),
        .MEM_WB_write_data (wdata),
        .ID_EX_flush       (flush),
        .ID_EX_wb          (o_wb),
        .ID_EX_m           (o_m),
        .ID_EX_ex          (o_ex),
        .ID_EX_npc         (o_npc),
        .ID_EX_readdat1    (o_rd1),
        .ID_EX_readdat2    (o_rd2),
        .ID_EX_sign_ext    (o_sext),
        .ID_EX_instr_2016  (o_i2016),
        .ID_EX_instr_1511  (o_i1511)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wb"},   32'(o_wb),    32'h0);
        chk({tag, " m"},    32'(o_m),     32'h0);
        chk({tag, " ex"},   32'(o_ex),    32'h0);
        chk({tag, " npc"},  o_npc,        32'h0);
        chk({tag, " rd1"},  o_rd1,        32'h0);
        chk({tag, " rd2"},  o_rd2,        32'h0);
        chk({tag, " sext"}, o_sext,       32'h0);
        chk({tag, " 2016"}, 32'(o_i2016), 32'h0);
        chk({tag, " 1511"}, 32'(o_i1511), 32'h0);
    endtask

    // Reference: control table from the opcode, reads see the same-cycle write.
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1100};
            6'h23:   return {2'b11, 3'b010, 4'b0001};
            6'h2B:   return {2'b00, 3'b001, 4'b0001};
            6'h04:   return {2'b00, 3'b100, 4'b0010};
            default: return 9'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (w && wa == a) return wd;
        return model_regs[a];
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic w,
                         input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        exp_t       e;
        logic [8:0] c;
        @(negedge clk);
        instr = ins; npc = pc; we = w; waddr = wa; wdata = wd; flush = fl;
        c       = fl ? 9'h0 : ref_ctrl(ins[31:26]);
        e.wb    = c[8:7];
        e.m     = c[6:4];
        e.ex    = c[3:0];
        e.npc   = pc;
        e.rd1   = ref_read(ins[25:21], w, wa, wd);
        e.rd2   = ref_read(ins[20:16], w, wa, wd);
        e.sext  = 32'($signed(ins[15:0]));
        e.i2016 = ins[20:16];
        e.i1511 = ins[15:11];
        sb_q.push_back(e);
        if (w && wa != 5'd0) model_regs[wa] = wd;
    endtask

    // Monitor: one ID/EX result per rising edge for each issued instruction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wb",   32'(o_wb),    32'(e.wb));
                chk("m",    32'(o_m),     32'(e.m));
                chk("ex",   32'(o_ex),    32'(e.ex));
                chk("npc",  o_npc,        e.npc);
                chk("rd1",  o_rd1,        e.rd1);
                chk("rd2",  o_rd2,        e.rd2);
                chk("sext", o_sext,       e.sext);
                chk("2016", 32'(o_i2016), 32'(e.i2016));
                chk("1511", 32'(o_i1511), 32'(e.i1511));
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        rst_n = 1'b0; instr = '0; npc = '0; we = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
        #2;
        chk_all_zero("init");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Write r3, then read it as rs of an add.
        issue({6'h3F, 26'h0}, 32'h100, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        issue({6'h00, 5'd3, 5'd0, 5'd4, 11'h020}, 32'h101, 1'b0, 5'd0, 32'h0, 1'b0);
        // Same-cycle bypass on rt.
        issue({6'h00, 5'd1, 5'd7, 5'd2, 11'h020}, 32'h102, 1'b1, 5'd7, 32'h12345678, 1'b0);
        // r0 is never written.
        issue({6'h3F, 26'h0}, 32'h103, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        issue({6'h00, 5'd0, 5'd0, 5'd1, 11'h020}, 32'h104, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        // Decode table and sign extension.
        issue(32'h8C4A8004, 32'h105, 1'b0, 5'd0, 32'h0, 1'b0);
        issue({6'h2B, 5'd3, 5'd7, 16'h0010}, 32'h106, 1'b0, 5'd0, 32'h0, 1'b0);
        issue({6'h04, 5'd3, 5'd7, 16'hFFFE}, 32'h107, 1'b0, 5'd0, 32'h0, 1'b0);
        issue({6'h3F, 5'd3, 5'd7, 16'h7FFF}, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
        // Flush bubbles control while a write still lands.
        issue(32'h8C4A8004, 32'h109, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1);
        issue({6'h00, 5'd9, 5'd3, 5'd5, 11'h020}, 32'h10A, 1'b0, 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ins = {op, 26'($urandom)};
            issue(ins, $urandom, ($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
                  ($urandom_range(0, 7) == 0));
        end

        // Mid-run reset: load r5, leave live values in ID/EX, then reset with a write pending.
        issue(32'h8C4A8004, 32'h200, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0);
        issue({6'h23, 5'd5, 5'd5, 16'h8001}, 32'h201, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
        #1;
        chk_all_zero("rst_async");
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        we = 1'b0; waddr = '0; wdata = '0;
        rst_n = 1'b1;
        issue({6'h00, 5'd5, 5'd5, 5'd6, 11'h020}, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0);
        issue({6'h3F, 26'h0}, 32'h301, 1'b0, 5'd0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the five-stage pipeline, directly downstream of the fetch stage. Consumes the IF/ID instruction and next-PC, reads two operands from a 32×32-bit register file, sign-extends the immediate and decodes the opcode into WB/M/EX control groups. Everything is latched into the ID/EX pipeline register on each rising clock edge. Also owns the register-file write port driven from the MEM/WB stage.

## Interface
- Parameters: none; widths are fixed at 32-bit data and 5-bit register addresses.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `IF_ID_instruction` in 32: instruction from the fetch stage.
- `IF_ID_npc` in 32: PC+1 from the fetch stage.
- `MEM_WB_reg_write` in 1: register-file write enable.
- `MEM_WB_write_reg` in 5: write address.
- `MEM_WB_write_data` in 32: write data.
- `ID_EX_flush` in 1: insert a bubble into ID/EX this edge.
- `ID_EX_wb` out 2: {RegWrite, MemtoReg}.
- `ID_EX_m` out 3: {Branch, MemRead, MemWrite}.
- `ID_EX_ex` out 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_npc` out 32: latched IF_ID_npc.
- `ID_EX_readdat1` out 32: value of rs (instr[25:21]).
- `ID_EX_readdat2` out 32: value of rt (instr[20:16]).
- `ID_EX_sign_ext` out 32: instr[15:0] sign-extended.
- `ID_EX_instr_2016` out 5: instr[20:16].
- `ID_EX_instr_1511` out 5: instr[15:11].

## Operation
- Opcode field is instr[31:26]. Decode, each listed as wb/m/ex:
  - 0x00 R-type: 2'b10 / 3'b000 / 4'b1100.
  - 0x23 lw: 2'b11 / 3'b010 / 4'b0001.
  - 0x2B sw: 2'b00 / 3'b001 / 4'b0001.
  - 0x04 beq: 2'b00 / 3'b100 / 4'b0010.
  - Any other opcode: all control bits 0 (NOP).
- Sign extension: {{16{instr[15]}}, instr[15:0]}.
- Register file writes:
  - Synchronous, on the rising edge, when MEM_WB_reg_write=1 and MEM_WB_write_reg≠0.
  - Writes to r0 are ignored.
  - r0 always reads 0.
- Reads are combinational with write-through bypass. If MEM_WB_reg_write=1, MEM_WB_write_reg≠0 and MEM_WB_write_reg equals the read address, the read returns MEM_WB_write_data in the same cycle. The value latched into ID/EX is therefore the value being written that cycle.
- ID_EX_flush=1 at an edge:
  - wb, m and ex latch as 0.
  - All data fields latch normally.
  - Flush does not block register-file writes.

## Timing
- Latency: one cycle. IF/ID inputs present before edge N appear on the ID_EX_* outputs after edge N.
- No handshake; the stage advances every cycle.
- Reset (rst_n=0, asynchronous):
  - All ID_EX_* outputs are 0 immediately.
  - All 32 registers are 0.
  - Outputs hold 0 until the first rising edge with rst_n=1.
- Reset asserted mid-operation discards the in-flight ID/EX contents and any pending write that cycle.
- Simultaneous write and read of the same register resolves by bypass (above).
- Simultaneous flush and write: the write completes; the control fields bubble.

## Structure
- Shared package holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - Control-group widths: WB_W=2, M_W=3, EX_W=4.
  - Per-opcode control constants.
- One sub-module, `reg_file`: 32×32 array with async active-low clear, one synchronous write port, two combinational read ports with bypass, r0 hardwired to zero.
- Control decode and the ID/EX register stay inline in `i_decode`.

## Test plan
- Reset: assert rst_n=0 mid-run. Expect all ID_EX_* outputs 0 immediately, then r5 reads 0 after release.
- Write-then-read:
  - Write r3=0xDEADBEEF via MEM_WB, next cycle present `add` with rs=3, rt=0.
  - Expect ID_EX_readdat1=0xDEADBEEF, ID_EX_readdat2=0, wb=2'b10, ex=4'b1100.
- Bypass: same cycle, write r7=0x12345678 and present an instruction with rt=7. Expect ID_EX_readdat2=0x12345678 after that edge.
- r0 protection: write r0=0xFFFFFFFF, then read rs=0. Expect 0.
- Decode and sign-extend: present lw imm 0x8004 (instr 0x8C4A8004), then sw, beq, and opcode 0x3F.
  - lw: sign_ext=0xFFFF8004, wb/m/ex=2'b11/3'b010/4'b0001.
  - sw, beq: their table values.
  - Opcode 0x3F: all control 0.
- Flush: present lw with ID_EX_flush=1. Expect wb/m/ex all 0 while npc, sign_ext and the register fields latch normally.
